// File: rtl/affine2_pkg.sv
// affine2_pkg: shared states, default geometry and address widths for the affine2 sequencer
package affine2_pkg;
    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
    localparam int AFFINE2_NBANK = 4;
    localparam int AFFINE2_NOUT = 60;
    localparam int AFFINE2_RD_LAT = 1;
    localparam int AFFINE2_IBANK_W = 2;
    localparam int AFFINE2_OBANK_W = 6;
endpackage

// File: rtl/affine2_seq_dly.sv
// affine2_seq_dly: LAT-stage shift register aligning accumulator strobes with imem read data
module affine2_seq_dly #(
    parameter int LAT = 1,
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sr [LAT];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[LAT-1];
endmodule

// File: rtl/affine2_seq.sv
// affine2_seq: imem/accumulator/omem sequencer for the affine2 layer.
// Define AFFINE2_SEQ_PERF_EN to build the saturating busy-cycle counter on perf_cycles.
module affine2_seq
    import affine2_pkg::*;
#(
    parameter int NBANK = AFFINE2_NBANK,
    parameter int NOUT = AFFINE2_NOUT,
    parameter int RD_LAT = AFFINE2_RD_LAT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [AFFINE2_IBANK_W-1:0] imem_bank,
    output logic                       imem_rd,
    output logic                       acc_en,
    output logic                       acc_clr,
    output logic [AFFINE2_IBANK_W-1:0] acc_sel,
    output logic [AFFINE2_OBANK_W-1:0] omem_bank,
    output logic                       omem_wr,
    output logic [15:0]                perf_cycles
);
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AFFINE2_IBANK_W-1:0] LAST_B = AFFINE2_IBANK_W'(NBANK - 1);
    localparam logic [AFFINE2_OBANK_W-1:0] LAST_O = AFFINE2_OBANK_W'(NOUT - 1);
    localparam logic [DW-1:0] LAST_D = DW'(RD_LAT - 1);
    state_t state;
    logic [AFFINE2_IBANK_W-1:0] b;
    logic [AFFINE2_OBANK_W-1:0] o;
    logic [DW-1:0] d;
    logic start_q;
    logic go;
    assign go = (state == IDLE) && start && !start_q;
    // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            b <= '0;
            o <= '0;
            d <= '0;
            start_q <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            imem_rd <= 1'b0;
            imem_bank <= '0;
            omem_wr <= 1'b0;
            omem_bank <= '0;
        end else begin
            start_q <= start;
            busy <= state inside {READ, DRAIN, WRITE};
            done <= state == DONE;
            imem_rd <= state == READ;
            imem_bank <= (state == READ) ? b : '0;
            omem_wr <= state == WRITE;
            omem_bank <= (state == WRITE) ? o : '0;
            case (state)
                IDLE: if (go) begin
                    state <= READ;
                    b <= '0;
                    o <= '0;
                end
                READ: begin
                    b <= b + 1'b1;
                    d <= '0;
                    if (b == LAST_B) state <= DRAIN;
                end
                DRAIN: begin
                    d <= d + 1'b1;
                    if (d == LAST_D) state <= WRITE;
                end
                WRITE: begin
                    state <= (o == LAST_O) ? DONE : READ;
                    o <= (o == LAST_O) ? o : o + 1'b1;
                    b <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    affine2_seq_dly #(.LAT(RD_LAT), .W(AFFINE2_IBANK_W + 2)) u_dly (
        .clock(clock),
        .reset(reset),
        .d({imem_rd, imem_rd && (imem_bank == '0), imem_bank}),
        .q({acc_en, acc_clr, acc_sel})
    );
`ifdef AFFINE2_SEQ_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) perf_cycles <= '0;
        else if (go) perf_cycles <= '0;
        else if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 1'b1;
    end
`else
    assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_affine2_seq.sv
// tb_affine2_seq: scoreboard bench for affine2_seq; expected omem writes are queued at start and popped on omem_wr
module tb_affine2_seq;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, imem_rd, acc_en, acc_clr, omem_wr;
    logic [1:0] imem_bank, acc_sel;
    logic [5:0] omem_bank;
    logic [15:0] perf_cycles;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;
    typedef struct {
        int t;
        int bank;
    } wr_t;
    wr_t q[$];
`ifdef AFFINE2_SEQ_PERF_EN
    localparam int PERF_RUN = 360;
`else
    localparam int PERF_RUN = 0;
`endif
    affine2_seq dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .imem_bank(imem_bank),
        .imem_rd(imem_rd),
        .acc_en(acc_en),
        .acc_clr(acc_clr),
        .acc_sel(acc_sel),
        .omem_bank(omem_bank),
        .omem_wr(omem_wr),
        .perf_cycles(perf_cycles)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    wire [15:0] outs = {busy, done, imem_bank, imem_rd, acc_en, acc_clr, acc_sel, omem_bank, omem_wr};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc - t0);
        end
    endtask
    task automatic wait_to(input int n);
        forever begin
            @(negedge clock);
            if (cyc >= t0 + n) break;
        end
    endtask
    // Called at a negedge: the next posedge is T0 of the run.
    task automatic start_run();
        start = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 60; k++) q.push_back('{t0 + 6 + 6 * k, k});
    endtask
    always @(negedge clock) begin
        if (reset && omem_wr) begin
            if (q.size() == 0) begin
                chk("spurious_wr", {26'd0, omem_bank}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_bank", {26'd0, omem_bank}, e.bank);
                chk("wr_time", cyc - t0, e.t - t0);
            end
        end
    end
    initial begin
        repeat (3) @(negedge clock);
        chk("rst_outs", {16'd0, outs}, 0);
        chk("rst_perf", {16'd0, perf_cycles}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_outs", {16'd0, outs}, 0);
        start_run();
        for (int n = 1; n <= 6; n++) begin
            wait_to(n);
            chk("imem_rd", {31'd0, imem_rd}, n <= 4);
            chk("imem_bank", {30'd0, imem_bank}, (n <= 4) ? n - 1 : 0);
            chk("acc_en", {31'd0, acc_en}, n >= 2 && n <= 5);
            chk("acc_clr", {31'd0, acc_clr}, n == 2);
            chk("acc_sel", {30'd0, acc_sel}, (n >= 2 && n <= 5) ? n - 2 : 0);
            chk("busy", {31'd0, busy}, 1);
        end
        wait_to(50);
        start = 1'b0;
        wait_to(99);
        start = 1'b1;
        wait_to(100);
        start = 1'b0;
        wait_to(150);
        start = 1'b1;
        wait_to(360);
        chk("done_t360", {31'd0, done}, 0);
        chk("busy_t360", {31'd0, busy}, 1);
        wait_to(361);
        chk("done_t361", {31'd0, done}, 1);
        chk("busy_t361", {31'd0, busy}, 0);
        chk("perf_end", {16'd0, perf_cycles}, PERF_RUN);
        wait_to(362);
        chk("done_t362", {31'd0, done}, 0);
        repeat (20) @(negedge clock);
        chk("no_restart", {16'd0, outs}, 0);
        chk("perf_hold", {16'd0, perf_cycles}, PERF_RUN);
        chk("wr_count", q.size(), 0);
        start = 1'b0;
        @(negedge clock);
        start_run();
        wait_to(65);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_outs", {16'd0, outs}, 0);
        chk("async_rst_perf", {16'd0, perf_cycles}, 0);
        q.delete();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_rst_idle", {16'd0, outs}, 0);
        start_run();
        wait_to(1);
        chk("rerun_imem_rd", {31'd0, imem_rd}, 1);
        chk("rerun_imem_bank", {30'd0, imem_bank}, 0);
        wait_to(361);
        chk("rerun_done", {31'd0, done}, 1);
        chk("rerun_perf", {16'd0, perf_cycles}, PERF_RUN);
        chk("rerun_wr_count", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
